// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants, FSM state and flag types for the FP64 post-add normalize/round stage
package fpu_pkg;

  localparam int MANT_W  = 53;
  localparam int EXP_W   = 11;
  localparam int BIAS    = 1023;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int LZC_W   = $clog2(MANT_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_RND,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
    logic zero;
  } flags_t;

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero counter over MANT_W bits
module fpu_lzc
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] data_i,
  output logic [LZC_W-1:0]  count_o
);

  logic found;

  // All-zero input reports MANT_W.
  always_comb begin
    count_o = LZC_W'(MANT_W);
    found   = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = LZC_W'(MANT_W - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_norm_round.sv
// rtl/fpu_norm_round.sv - FP64 normalize, round-to-nearest-even and pack stage (option: FPU_FLUSH_DENORM_EN)
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W:0]           mant_in,
  input  logic                      sign_in,
  input  logic [EXP_W-1:0]          exp_in,
  input  logic [2:0]                grs_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANT_W+EXP_W-1:0]   result,
  output logic                      flag_ovf,
  output logic                      flag_unf,
  output logic                      flag_inx,
  output logic                      flag_zero
);

  localparam int SW = EXP_W + 2;
  localparam logic signed [SW-1:0] EXP_MAX_S = SW'(EXP_MAX);

  state_e state_q, state_d;

  logic [MANT_W:0]   mant_q;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [2:0]        grs_q;

  logic [MANT_W-1:0]     nm_q;
  logic                  ng_q, nr_q, ns_q;
  logic signed [SW-1:0]  nexp_q;
  logic                  nzero_q, nden_q, nsign_q;

  logic [MANT_W+EXP_W-1:0] result_q, result_d;
  flags_t                  flags_q, flags_d;

  logic [LZC_W-1:0]      lz;
  logic signed [SW-1:0]  e_in, lim, lz_s, sh;
  logic [MANT_W+2:0]     wide;
  logic [MANT_W-1:0]     n_m;
  logic                  n_g, n_r, n_s, n_zero, n_den;
  logic signed [SW-1:0]  n_e;

  logic                  up, hidden, inx;
  logic [MANT_W:0]       sum;
  logic signed [SW-1:0]  e_r;
  logic [EXP_W-1:0]      exp_f;
  logic [MANT_W-2:0]     frac;

  fpu_lzc u_lzc (
    .data_i  (mant_q[MANT_W-1:0]),
    .count_o (lz)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_NORM;
      ST_NORM: state_d = ST_RND;
      ST_RND:  state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero exponent field means the operand is already subnormal: treat it as exponent 1.
  always_comb begin
    e_in   = (exp_q == '0) ? SW'(1) : SW'(exp_q);
    lim    = e_in - SW'(1);
    lz_s   = SW'(lz);
    sh     = (lz_s > lim) ? lim : lz_s;
    wide   = {mant_q[MANT_W-1:0], grs_q} << sh;
    n_m    = wide[MANT_W+2:3];
    n_g    = wide[2];
    n_r    = wide[1];
    n_s    = wide[0];
    n_e    = e_in - sh;
    if (mant_q[MANT_W]) begin
      n_m = mant_q[MANT_W:1];
      n_g = mant_q[0];
      n_r = grs_q[2];
      n_s = grs_q[1] | grs_q[0];
      n_e = e_in + SW'(1);
    end
    n_zero = (mant_q == '0) && (grs_q == 3'b000);
    n_den  = ~n_m[MANT_W-1] & ~n_zero;
  end

  // A denormal that rounds into the hidden position keeps nexp_q (=1) as its field.
  always_comb begin
    up       = ng_q & (nr_q | ns_q | nm_q[0]);
    sum      = {1'b0, nm_q} + {{MANT_W{1'b0}}, up};
    e_r      = nexp_q + SW'(sum[MANT_W]);
    hidden   = sum[MANT_W] | sum[MANT_W-1];
    frac     = sum[MANT_W] ? '0 : sum[MANT_W-2:0];
    inx      = ng_q | nr_q | ns_q;
    exp_f    = hidden ? e_r[EXP_W-1:0] : '0;
    result_d = '0;
    flags_d  = '0;
    if (nzero_q) begin
      flags_d.zero = 1'b1;
    end else if (e_r >= EXP_MAX_S) begin
      result_d    = {nsign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      flags_d.ovf = 1'b1;
      flags_d.inx = 1'b1;
    end else begin
`ifdef FPU_FLUSH_DENORM_EN
      if (nden_q || !hidden) begin
        result_d     = {nsign_q, {EXP_W{1'b0}}, {(MANT_W-1){1'b0}}};
        flags_d.unf  = 1'b1;
        flags_d.zero = 1'b1;
        flags_d.inx  = 1'b1;
      end else begin
        result_d    = {nsign_q, exp_f, frac};
        flags_d.inx = inx;
      end
`else
      result_d     = {nsign_q, exp_f, frac};
      flags_d.inx  = inx;
      flags_d.unf  = ~hidden & inx;
      flags_d.zero = (exp_f == '0) && (frac == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mant_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      grs_q    <= '0;
      nm_q     <= '0;
      ng_q     <= 1'b0;
      nr_q     <= 1'b0;
      ns_q     <= 1'b0;
      nexp_q   <= '0;
      nzero_q  <= 1'b0;
      nden_q   <= 1'b0;
      nsign_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        mant_q <= mant_in;
        sign_q <= sign_in;
        exp_q  <= exp_in;
        grs_q  <= grs_in;
      end
      if (state_q == ST_NORM) begin
        nm_q    <= n_m;
        ng_q    <= n_g;
        nr_q    <= n_r;
        ns_q    <= n_s;
        nexp_q  <= n_e;
        nzero_q <= n_zero;
        nden_q  <= n_den;
        nsign_q <= sign_q & ~n_zero;
      end
      if (state_q == ST_RND) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign flag_ovf  = flags_q.ovf;
  assign flag_unf  = flags_q.unf;
  assign flag_inx  = flags_q.inx;
  assign flag_zero = flags_q.zero;

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb/tb_fpu_norm_round.sv - scoreboard bench for fpu_norm_round with directed vectors
module tb_fpu_norm_round;

`ifdef FPU_FLUSH_DENORM_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [53:0] mant_in = '0;
  logic        sign_in = 1'b0;
  logic [10:0] exp_in = '0;
  logic [2:0]  grs_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        flag_ovf, flag_unf, flag_inx, flag_zero;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  fpu_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .grs_in    (grs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx),
    .flag_zero (flag_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", result, 64'hx);
      end else begin
        mon_e = q.pop_front();
        check("result", result, mon_e.res);
        check("flags", {60'd0, flag_ovf, flag_unf, flag_inx, flag_zero}, {60'd0, mon_e.flg});
      end
    end
  end

  task automatic send(input logic [53:0] m, input logic [10:0] e, input logic [2:0] g,
                      input logic s, input logic [63:0] r, input logic [3:0] f);
    int n;
    exp_t x;
    x.res = r;
    x.flg = f;
    q.push_back(x);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    mant_in  = m;
    exp_in   = e;
    grs_in   = g;
    sign_in  = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    // Edges after the accepting edge until out_valid: accept edge counts as the first of three.
    check("latency", 64'(n), 64'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", {60'd0, flag_ovf, flag_unf, flag_inx, flag_zero}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // flags order: {ovf, unf, inx, zero}
    send(54'h20000000000000, 11'h3FF, 3'b000, 1'b0, 64'h4000000000000000, 4'b0000);
    send(54'h00000000000001, 11'h3FF, 3'b000, 1'b1, 64'hBCB0000000000000, 4'b0000);
    send(54'h00000000000000, 11'h123, 3'b000, 1'b1, 64'h0000000000000000, 4'b0001);
    send(54'h1FFFFFFFFFFFFF, 11'h3FF, 3'b100, 1'b0, 64'h4000000000000000, 4'b0010);
    send(54'h20000000000000, 11'h7FE, 3'b000, 1'b0, 64'h7FF0000000000000, 4'b1010);
    send(54'h10000000000000, 11'h3FF, 3'b100, 1'b0, 64'h3FF0000000000000, 4'b0010);
    send(54'h10000000000001, 11'h3FF, 3'b100, 1'b0, 64'h3FF0000000000002, 4'b0010);
    send(54'h20000000000001, 11'h3FF, 3'b000, 1'b0, 64'h4000000000000000, 4'b0010);
    send(54'h18000000000000, 11'h400, 3'b000, 1'b1, 64'hC008000000000000, 4'b0000);
    send(54'h00000000000001, 11'h001, 3'b000, 1'b0,
         FLUSH ? 64'h0 : 64'h0000000000000001, FLUSH ? 4'b0111 : 4'b0000);
    send(54'h0FFFFFFFFFFFFF, 11'h001, 3'b110, 1'b0,
         FLUSH ? 64'h0 : 64'h0010000000000000, FLUSH ? 4'b0111 : 4'b0010);
    send(54'h00000000000002, 11'h001, 3'b100, 1'b1,
         FLUSH ? 64'h8000000000000000 : 64'h8000000000000002, FLUSH ? 4'b0111 : 4'b0110);
    send(54'h00000000000001, 11'h003, 3'b000, 1'b0,
         FLUSH ? 64'h0 : 64'h0000000000000004, FLUSH ? 4'b0111 : 4'b0000);

    // Back-pressure: result held, new operands ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(54'h10000000000000, 11'h3FF, 3'b000, 1'b0, 64'h3FF0000000000000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      mant_in  = 54'h20000000000000;
      exp_in   = 11'h7FE;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", result, 64'h3FF0000000000000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);

    // Reset during NORM discards the operand.
    mant_in  = 54'h20000000000000;
    exp_in   = 11'h3FF;
    grs_in   = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_output", {63'd0, out_valid}, 64'd0);

    send(54'h00000000000001, 11'h3FF, 3'b000, 1'b1, 64'hBCB0000000000000, 4'b0000);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
